sync_fifo_th: RTL and testbench
===============================

SYNC_FIFO_TH -- requirements
Module: sync_fifo_th

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries, power of two, at least 4.
REQ-003 SHALL have parameter PTR_ADDR, default 4, log2(DEPTH).
REQ-004 SHALL have parameter AF_LEVEL, default 12, count at or above which almost_full_o asserts.
REQ-005 SHALL have parameter AE_LEVEL, default 4, count at or below which almost_empty_o asserts.
REQ-006 SHALL have port clk_i, input, 1, single clock, all state on rising edge.
REQ-007 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port wr_en_i, input, 1, write request.
REQ-009 SHALL have port wdata_i, input, WIDTH, write data.
REQ-010 SHALL have port rd_en_i, input, 1, read request.
REQ-011 SHALL have port rdata_o, output, WIDTH, read data.
REQ-012 SHALL have port rvalid_o, output, 1, rdata_o holds a freshly popped word.
REQ-013 SHALL have ports full_o, empty_o, almost_full_o and almost_empty_o, each output, 1, status flags.
REQ-014 SHALL have port count_o, output, PTR_ADDR+1, current occupancy 0..DEPTH.
REQ-015 SHALL have ports wr_error_o and rd_error_o, each output, 1, one-cycle pulse on a rejected request.

Function
REQ-016 SHALL track occupancy with wr/rd pointers of PTR_ADDR bits plus a wrap bit each; pointers wrap DEPTH-1 -> 0 and toggle their wrap bit.
REQ-017 SHALL derive empty_o = (ptrs equal, wrap bits equal) and full_o = (ptrs equal, wrap bits differ), both reflecting state after the last clock edge.
REQ-018 SHALL compute count_o = {wr_wrap,wr_ptr} - {rd_wrap,rd_ptr} modulo 2*DEPTH.
REQ-019 SHALL assert almost_full_o iff count_o >= AF_LEVEL and almost_empty_o iff count_o <= AE_LEVEL.
REQ-020 SHALL, on wr_en_i with not full, store wdata_i at wr_ptr and advance wr_ptr.
REQ-021 SHALL, on wr_en_i while full and rd_en_i low, drop the write, hold state and pulse wr_error_o for one cycle.
REQ-022 SHALL, on wr_en_i and rd_en_i both high while full, accept both (read pops oldest, write fills freed slot); count unchanged, no error.
REQ-023 SHALL, on rd_en_i while empty, pulse rd_error_o for one cycle and leave rdata_o unchanged, even if wr_en_i is high (the write is still accepted).
REQ-024 SHALL, on rd_en_i with not empty, advance rd_ptr; in standard mode rdata_o = popped word registered one cycle after the edge and rvalid_o pulses high for that cycle.
REQ-025 SHALL, when both requests are accepted and the FIFO is neither full nor empty, leave count_o unchanged.
REQ-026 SHALL hold error outputs low in any cycle without a rejected request.

Reset
REQ-027 SHALL, while rst_ni is low, immediately force rdata_o=0, rvalid_o=0, count_o=0, empty_o=1, full_o=0, almost_full_o=0, almost_empty_o=1, wr_error_o=0, rd_error_o=0, and both pointers and wrap bits to 0.
REQ-028 SHALL NOT reset storage contents; data written before a mid-operation reset is lost, and the first post-reset write lands in entry 0.
REQ-029 SHALL resume operation on the first rising clk_i edge after rst_ni deasserts.

Configuration
REQ-030 SHALL, with macro SYNC_FIFO_FWFT_EN defined, operate first-word-fall-through: rdata_o combinationally equals the head entry whenever not empty, rvalid_o = ~empty_o, and rd_en_i acknowledges and pops the head.
REQ-031 SHALL, without SYNC_FIFO_FWFT_EN, use the registered one-cycle read latency of REQ-024.

Verification
REQ-032 SHALL cover reset then write 0x01..0x10 -> after 16th write full_o=1, count_o=16, almost_full_o=1 from 12th write; 17th write -> wr_error_o pulse, count_o stays 16.
REQ-033 SHALL cover reading a full FIFO 16 times -> rdata_o 0x01..0x10 in order, rvalid_o pulse per read (standard mode), empty_o=1 after last read; 17th read -> rd_error_o pulse.
REQ-034 SHALL cover full FIFO plus simultaneous wr_en_i=rd_en_i=1 with wdata 0xAA -> head 0x01 read, full_o stays 1, no errors, 0xAA read 16th later.
REQ-035 SHALL cover 40 write/read cycles crossing wrap twice -> data order preserved, count_o never exceeds 16.
REQ-036 SHALL cover asserting rst_ni low mid-burst at count 7 -> all outputs take reset values without a clock edge; next write 0x55 then read -> 0x55.
REQ-037 SHALL cover SYNC_FIFO_FWFT_EN build: write 0x33 to empty FIFO -> rdata_o=0x33, rvalid_o=1 next cycle with no read; rd_en_i -> empty_o=1.

Source files
------------

// File: rtl/sync_fifo_th.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is one-cycle registered reads.
module sync_fifo_th #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int PTR_ADDR = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_en_i,
    input  logic [WIDTH-1:0]    wdata_i,
    input  logic                rd_en_i,
    output logic [WIDTH-1:0]    rdata_o,
    output logic                rvalid_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic [PTR_ADDR:0]   count_o,
    output logic                wr_error_o,
    output logic                rd_error_o
);

    localparam int CW = PTR_ADDR + 1;
    localparam logic [PTR_ADDR:0] PTR_ONE = CW'(1);
    localparam logic [PTR_ADDR:0] AF_CNT  = CW'(AF_LEVEL);
    localparam logic [PTR_ADDR:0] AE_CNT  = CW'(AE_LEVEL);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_ADDR:0] wr_ptr;
    logic [PTR_ADDR:0] rd_ptr;
    logic              wr_accept;
    logic              rd_accept;
    logic              wr_reject;
    logic              rd_reject;
    logic              wr_error_p1;
    logic              rd_error_p1;

    // Top pointer bit is the wrap bit; the subtraction wraps modulo 2*DEPTH on its own.
    assign empty_o        = (wr_ptr == rd_ptr);
    assign full_o         = (wr_ptr[PTR_ADDR-1:0] == rd_ptr[PTR_ADDR-1:0]) &&
                            (wr_ptr[PTR_ADDR] != rd_ptr[PTR_ADDR]);
    assign count_o        = wr_ptr - rd_ptr;
    assign almost_full_o  = (count_o >= AF_CNT);
    assign almost_empty_o = (count_o <= AE_CNT);

    // A write into a full FIFO is still taken when a read frees the head slot.
    assign rd_accept = rd_en_i & ~empty_o;
    assign wr_accept = wr_en_i & (~full_o | rd_en_i);
    assign wr_reject = wr_en_i & full_o & ~rd_en_i;
    assign rd_reject = rd_en_i & empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_error_p1 <= 1'b0;
            rd_error_p1 <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
            wr_error_p1 <= wr_reject;
            rd_error_p1 <= rd_reject;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_accept) mem[wr_ptr[PTR_ADDR-1:0]] <= wdata_i;
    end

    assign wr_error_o = wr_error_p1;
    assign rd_error_o = rd_error_p1;

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata_o  = empty_o ? '0 : mem[rd_ptr[PTR_ADDR-1:0]];
    assign rvalid_o = ~empty_o;
`else
    logic [WIDTH-1:0] rdata_p1;
    logic             vld_p1;

    // Read stage: popped word and its valid land one cycle after the accepting edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= rd_accept;
            if (rd_accept) rdata_p1 <= mem[rd_ptr[PTR_ADDR-1:0]];
        end
    end

    assign rdata_o  = rdata_p1;
    assign rvalid_o = vld_p1;
`endif

endmodule

// File: tb/tb_sync_fifo_th.sv
// Directed bench for sync_fifo_th: fill/overflow, drain/underflow, full simultaneous access,
// wrap-around streaming and asynchronous mid-burst reset (FWFT build gets its own short sequence).
module tb_sync_fifo_th;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic [7:0] rdata;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       wr_error;
    logic       rd_error;

    int n_checks = 0;
    int n_fails  = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_word;

    sync_fifo_th dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wr_en_i        (wr_en),
        .wdata_i        (wdata),
        .rd_en_i        (rd_en),
        .rdata_o        (rdata),
        .rvalid_o       (rvalid),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .count_o        (count),
        .wr_error_o     (wr_error),
        .rd_error_o     (rd_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_wr_err", 32'(wr_error), 32'd0);
        check("rst_rd_err", 32'(rd_error), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 8'h00;
        #3;
        check_reset_state();
        step();
        rst_n = 1'b1;
        step();

`ifdef SYNC_FIFO_FWFT_EN
        wr_en = 1'b1; wdata = 8'h33;
        step();
        wr_en = 1'b0;
        check("fwft_rdata", 32'(rdata), 32'h33);
        check("fwft_rvalid", 32'(rvalid), 32'd1);
        check("fwft_empty", 32'(empty), 32'd0);
        step();
        check("fwft_hold", 32'(rdata), 32'h33);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("fwft_empty_after", 32'(empty), 32'd1);
        check("fwft_rvalid_after", 32'(rvalid), 32'd0);
        check("fwft_count", 32'(count), 32'd0);
`else
        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wdata = 8'(i);
            step();
            check("fill_count", 32'(count), 32'(i));
            check("fill_af", 32'(almost_full), 32'(i >= 12));
            check("fill_ae", 32'(almost_empty), 32'(i <= 4));
            check("fill_full", 32'(full), 32'(i == 16));
        end
        wdata = 8'h77;
        step();
        wr_en = 1'b0;
        check("ovf_wr_err", 32'(wr_error), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_rd_err", 32'(rd_error), 32'd0);
        step();
        check("ovf_pulse_end", 32'(wr_error), 32'd0);

        // Simultaneous read/write while full
        wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hAA;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("sim_rdata", 32'(rdata), 32'h01);
        check("sim_rvalid", 32'(rvalid), 32'd1);
        check("sim_full", 32'(full), 32'd1);
        check("sim_count", 32'(count), 32'd16);
        check("sim_wr_err", 32'(wr_error), 32'd0);
        check("sim_rd_err", 32'(rd_error), 32'd0);

        // Drain: 0x02..0x10 then 0xAA
        for (int k = 1; k <= 16; k++) begin
            rd_en = 1'b1;
            step();
            check("drain_rdata", 32'(rdata), (k == 16) ? 32'hAA : 32'(k + 1));
            check("drain_rvalid", 32'(rvalid), 32'd1);
            check("drain_count", 32'(count), 32'(16 - k));
            check("drain_ae", 32'(almost_empty), 32'((16 - k) <= 4));
        end
        check("drain_empty", 32'(empty), 32'd1);
        step();
        rd_en = 1'b0;
        check("udf_rd_err", 32'(rd_error), 32'd1);
        check("udf_rvalid", 32'(rvalid), 32'd0);
        check("udf_rdata_hold", 32'(rdata), 32'hAA);
        step();
        check("udf_pulse_end", 32'(rd_error), 32'd0);

        // Read on empty with concurrent write: write taken, read rejected
        wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h5A;
        step();
        wr_en = 1'b0;
        check("emp_rw_rd_err", 32'(rd_error), 32'd1);
        check("emp_rw_count", 32'(count), 32'd1);
        check("emp_rw_rdata_hold", 32'(rdata), 32'hAA);
        step();
        rd_en = 1'b0;
        check("emp_rw_rdata", 32'(rdata), 32'h5A);
        check("emp_rw_rvalid", 32'(rvalid), 32'd1);
        check("emp_rw_empty", 32'(empty), 32'd1);

        // Prefill 8 then stream 40 simultaneous cycles across the wrap point
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wdata = 8'(8'h80 + i);
            model_q.push_back(wdata);
            step();
        end
        check("pre_count", 32'(count), 32'd8);
        for (int i = 8; i < 48; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wdata = 8'(8'h80 + i);
            model_q.push_back(wdata);
            exp_word = model_q.pop_front();
            step();
            check("wrap_rdata", 32'(rdata), 32'(exp_word));
            check("wrap_count", 32'(count), 32'd8);
        end
        wr_en = 1'b0;
        exp_word = model_q.pop_front();
        step();
        rd_en = 1'b0;
        check("burst_rdata", 32'(rdata), 32'(exp_word));
        check("burst_count", 32'(count), 32'd7);

        // Asynchronous reset mid-burst, away from any clock edge
        wr_en = 1'b1; wdata = 8'hEE;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        wr_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        wr_en = 1'b1; wdata = 8'h55;
        step();
        wr_en = 1'b0;
        check("post_rst_count", 32'(count), 32'd1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("post_rst_rdata", 32'(rdata), 32'h55);
        check("post_rst_rvalid", 32'(rvalid), 32'd1);
        check("post_rst_empty", 32'(empty), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
